vector_from_polar: RTL and testbench

- Sequential CORDIC (rotation mode) that converts a polar vector (magnitude, angle) into Cartesian components x, y.
- It is the inverse path of the combinational magnitude estimator: that block turns (x, y) into a length; this block turns a length and direction back into (x, y).
- Valid/ready handshake on input and output; one vector in flight at a time.
- Used as a stimulus source for vector datapaths and as a lab exercise in iterative arithmetic.

---
 rtl/vector_from_polar.sv | 182 ++++++++++++++++++
 tb/tb_vector_from_polar.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/vector_from_polar.sv
// Iterative rotation-mode CORDIC: (magnitude, angle) -> signed (x, y), one vector in flight.
// Define VECTOR_FROM_POLAR_ROUND_EN to round half-up when dropping guard bits (default truncates).
module vector_from_polar #(
    parameter int MAG_W = 16,
    parameter int ANG_W = 16,
    parameter int ITER  = 16,
    parameter int GUARD = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [MAG_W-1:0]        mag_i,
    input  logic [ANG_W-1:0]        angle_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic signed [MAG_W:0]   x_o,
    output logic signed [MAG_W:0]   y_o
);

    localparam int DW    = MAG_W + 2 + GUARD;
    localparam int ZW    = ANG_W + 1;
    localparam int PW    = MAG_W + 16;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int QTR   = 2 ** (ANG_W - 2);
    localparam logic [15:0] K_INV = 16'd39797;
    localparam logic signed [DW-1:0] OUT_MAX = {{(DW-MAG_W){1'b0}}, {MAG_W{1'b1}}};
    localparam logic signed [DW-1:0] OUT_MIN = ~OUT_MAX;

    typedef enum logic [1:0] {IDLE, ROTATE, FINISH, DONE} state_t;

    state_t                 state, state_nx;
    logic [CNT_W-1:0]       cnt;
    logic                   load;
    logic                   last_iter;

    logic signed [DW-1:0]   x_r, y_r;
    logic signed [ZW-1:0]   z_r;
    logic                   neg_r;

    logic [PW-1:0]          prod;
    logic signed [DW-1:0]   x_ld;
    logic signed [ZW-1:0]   z_ld;
    logic                   neg_ld;
    int                     a_int;

    logic signed [DW-1:0]   x_sh, y_sh, x_it, y_it;
    logic signed [ZW-1:0]   z_it, atan_i;
    logic signed [DW-1:0]   x_g, y_g;

    // atan(2^-i) in angle units; the table is scaled from its 16-bit form for other widths
    function automatic logic signed [ZW-1:0] atan_lut(input int i);
        int base;
        case (i)
            0:       base = 8192;
            1:       base = 4836;
            2:       base = 2555;
            3:       base = 1297;
            4:       base = 651;
            5:       base = 326;
            6:       base = 163;
            7:       base = 81;
            8:       base = 41;
            9:       base = 20;
            10:      base = 10;
            11:      base = 5;
            12:      base = 3;
            13:      base = 1;
            14:      base = 1;
            default: base = 0;
        endcase
        if (ANG_W >= 16) return ZW'(base <<< (ANG_W - 16));
        else             return ZW'(base >>> (16 - ANG_W));
    endfunction

    function automatic logic signed [DW-1:0] drop_guard(input logic signed [DW-1:0] v);
`ifdef VECTOR_FROM_POLAR_ROUND_EN
        logic signed [DW-1:0] half;
        half = DW'(2 ** (GUARD - 1));
        return (v + half) >>> GUARD;
`else
        return v >>> GUARD;
`endif
    endfunction

    function automatic logic signed [MAG_W:0] sat_out(input logic signed [DW-1:0] v);
        if (v > OUT_MAX) return OUT_MAX[MAG_W:0];
        if (v < OUT_MIN) return OUT_MIN[MAG_W:0];
        return v[MAG_W:0];
    endfunction

    // Load: gain pre-compensation, and angles beyond +/-90 deg rotate by a-180 then negate
    always_comb begin
        prod   = PW'(mag_i) * PW'(K_INV);
        x_ld   = DW'(prod >> (16 - GUARD));
        a_int  = int'($signed(angle_i));
        neg_ld = (a_int > QTR) || (a_int < -QTR);
        if (neg_ld) z_ld = ZW'($signed({~angle_i[ANG_W-1], angle_i[ANG_W-2:0]}));
        else        z_ld = ZW'($signed(angle_i));
    end

    // Rotate: one micro-rotation per cycle, direction from the sign of the residual angle
    always_comb begin
        x_sh   = x_r >>> cnt;
        y_sh   = y_r >>> cnt;
        atan_i = atan_lut(int'(cnt));
        if (!z_r[ZW-1]) begin
            x_it = x_r - y_sh;
            y_it = y_r + x_sh;
            z_it = z_r - atan_i;
        end else begin
            x_it = x_r + y_sh;
            y_it = y_r - x_sh;
            z_it = z_r + atan_i;
        end
    end

    // Finish: drop guard bits, then undo the half-turn reflection
    always_comb begin
        x_g = drop_guard(x_r);
        y_g = drop_guard(y_r);
        if (neg_r) begin
            x_g = -x_g;
            y_g = -y_g;
        end
    end

    always_comb begin
        state_nx    = state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        load        = 1'b0;
        case (state)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    load     = 1'b1;
                    state_nx = ROTATE;
                end
            end
            ROTATE:  if (last_iter) state_nx = FINISH;
            FINISH:  state_nx = DONE;
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign last_iter = (cnt == CNT_W'(ITER - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
            x_o   <= '0;
            y_o   <= '0;
        end else begin
            state <= state_nx;
            if (state == ROTATE) cnt <= last_iter ? '0 : cnt + 1'b1;
            if (state == FINISH) begin
                x_o <= sat_out(x_g);
                y_o <= sat_out(y_g);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (load) begin
            x_r   <= x_ld;
            y_r   <= '0;
            z_r   <= z_ld;
            neg_r <= neg_ld;
        end else if (state == ROTATE) begin
            x_r <= x_it;
            y_r <= y_it;
            z_r <= z_it;
        end
    end

endmodule

// File: tb/tb_vector_from_polar.sv
// Bench for vector_from_polar: directed quadrant/boundary cases, handshake, reset, random sweep
// against a real-valued cos/sin reference.
module tb_vector_from_polar;

    localparam int  MAG_W = 16;
    localparam int  ANG_W = 16;
    localparam int  ITER  = 16;
    localparam int  GUARD = 3;
    localparam real PI    = 3.14159265358979;
`ifdef VECTOR_FROM_POLAR_ROUND_EN
    localparam int  BASE_TOL = 3;
`else
    localparam int  BASE_TOL = 4;
`endif
    // The integer atan table leaves up to ~5 angle units of residual rotation,
    // which scales with magnitude on top of the datapath tolerance.
    localparam real RES_UNITS = 5.0;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid, in_ready, out_valid, out_ready;
    logic [MAG_W-1:0]       mag;
    logic [ANG_W-1:0]       angle;
    logic signed [MAG_W:0]  x_out, y_out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vector_from_polar #(.MAG_W(MAG_W), .ANG_W(ANG_W), .ITER(ITER), .GUARD(GUARD)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .mag_i      (mag),
        .angle_i    (angle),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .x_o        (x_out),
        .y_o        (y_out)
    );

    task automatic check_val(input string tag, input int got, input int exp, input int tol);
        n_cmp++;
        if (got - exp > tol || exp - got > tol) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    function automatic int ref_x(input int m, input int a);
        real th;
        th = 2.0 * PI * real'(a) / real'(2 ** ANG_W);
        return int'(real'(m) * $cos(th));
    endfunction

    function automatic int ref_y(input int m, input int a);
        real th;
        th = 2.0 * PI * real'(a) / real'(2 ** ANG_W);
        return int'(real'(m) * $sin(th));
    endfunction

    function automatic int tol_for(input int m);
        return BASE_TOL + int'($ceil(real'(m) * RES_UNITS * 2.0 * PI / real'(2 ** ANG_W)));
    endfunction

    task automatic wait_result(output int lat, output logic ok);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        ok = out_valid;
    endtask

    task automatic send(input int m, input int a, output int lat, output logic ok);
        int w;
        mag      = MAG_W'(m);
        angle    = ANG_W'(a);
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result(lat, ok);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_check(input string tag, input int m, input int a, input int tol,
                             input bit chk_lat);
        int   lat;
        logic ok;
        send(m, a, lat, ok);
        check_val({tag, "_vld"}, int'(ok), 1, 0);
        if (chk_lat) check_val({tag, "_lat"}, lat, ITER + 1, 0);
        check_val({tag, "_x"}, int'(x_out), ref_x(m, a), tol);
        check_val({tag, "_y"}, int'(y_out), ref_y(m, a), tol);
        release_out();
    endtask

    initial begin
        int   lat, changes, m, a;
        logic ok;
        logic signed [MAG_W:0] x_hold, y_hold;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mag = '0; angle = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rst_rdy", int'(in_ready), 1, 0);
        check_val("rst_vld", int'(out_valid), 0, 0);
        check_val("rst_x",   int'(x_out), 0, 0);
        check_val("rst_y",   int'(y_out), 0, 0);

        run_check("a0",    10000, 'h0000, tol_for(10000), 1'b1);
        run_check("a90",   10000, 'h4000, tol_for(10000), 1'b1);
        run_check("a180",  20000, 'h8000, tol_for(20000), 1'b0);
        run_check("a270",  20000, 'hC000, tol_for(20000), 1'b0);
        run_check("a45",   65535, 'h2000, tol_for(65535), 1'b0);
        run_check("a90p",  40000, 'h4001, tol_for(40000), 1'b0);
        run_check("a270m", 40000, 'hBFFF, tol_for(40000), 1'b0);
        run_check("a180m", 50000, 'h7FFF, tol_for(50000), 1'b0);

        for (int i = 0; i < 5; i++) run_check("zero", 0, int'($urandom_range(0, 65535)), 0, 1'b0);

        // Backpressure: result held while a second request waits
        send(30000, 'h1555, lat, ok);
        check_val("bp_first_vld", int'(ok), 1, 0);
        mag = MAG_W'(1234); angle = ANG_W'('h6000); in_valid = 1'b1;
        x_hold = x_out; y_hold = y_out; changes = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check_val("bp_vld", int'(out_valid), 1, 0);
            check_val("bp_rdy", int'(in_ready), 0, 0);
            if (x_out !== x_hold || y_out !== y_hold) changes++;
        end
        check_val("bp_stable", changes, 0, 0);
        check_val("bp_x", int'(x_out), ref_x(30000, 'h1555), tol_for(30000));
        check_val("bp_y", int'(y_out), ref_y(30000, 'h1555), tol_for(30000));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val("bp_rdy_after", int'(in_ready), 1, 0);
        check_val("bp_vld_after", int'(out_valid), 0, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result(lat, ok);
        check_val("bp2_lat", lat, ITER + 1, 0);
        check_val("bp2_x", int'(x_out), ref_x(1234, 'h6000), tol_for(1234));
        check_val("bp2_y", int'(y_out), ref_y(1234, 'h6000), tol_for(1234));
        release_out();

        // Reset during the fifth ROTATE cycle
        mag = MAG_W'(25000); angle = ANG_W'('h3000); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("mid_rst_rdy", int'(in_ready), 1, 0);
        check_val("mid_rst_vld", int'(out_valid), 0, 0);
        check_val("mid_rst_x",   int'(x_out), 0, 0);
        check_val("mid_rst_y",   int'(y_out), 0, 0);
        repeat (20) @(posedge clk);
        #1;
        check_val("mid_rst_discard", int'(out_valid), 0, 0);
        run_check("post_rst", 25000, 'h3000, tol_for(25000), 1'b1);

        for (int i = 0; i < 200; i++) begin
            m = int'($urandom_range(0, 65535));
            a = int'($urandom_range(0, 65535));
            run_check("rand", m, a, tol_for(m), 1'b0);
        end

        if (n_err == 0) $display("SUCCESS!");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
